// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: turns one decoded load/store into a single data-memory bus
// transaction with byte enables, store replication, load extension and error flags.
module lsu_mem_ctrl #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mr,
   input  logic        mw,
   input  logic [2:0]  MemType,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic        done,
   output logic [31:0] rdata,
   output logic        rdata_valid,
   output logic        err,
   output logic [1:0]  err_code,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_DONE
   } state_t;

   localparam logic [1:0] EC_MISALIGN = 2'b01;
   localparam logic [1:0] EC_ILLEGAL  = 2'b10;
   localparam logic [1:0] EC_TIMEOUT  = 2'b11;
   localparam logic [7:0] CNT_LAST    = 8'(TIMEOUT - 1);

   state_t      state;
   logic [7:0]  cnt;
   logic [2:0]  ld_type;
   logic [1:0]  ld_off;
   logic        is_load;

   logic        start;
   logic        illegal;
   logic        misalign;
   logic [3:0]  be_c;
   logic [31:0] wdata_c;
   logic [31:0] ld_ext;

   assign start = mr | mw;
   assign stall = ((state == S_IDLE) && start) || (state == S_REQ);

   // Access size comes from MemType[1:0]: 00 byte, 01 half, 10 word.
   always_comb begin
      illegal = 1'b0;
      if (mr && mw)
         illegal = 1'b1;
      else if (mr)
         illegal = (MemType == 3'b011) || (MemType == 3'b110) || (MemType == 3'b111);
      else if (mw)
         illegal = (MemType != 3'b000) && (MemType != 3'b001) && (MemType != 3'b010);
   end

   always_comb begin
      misalign = 1'b0;
      case (MemType[1:0])
         2'b01:   misalign = addr[0];
         2'b10:   misalign = (addr[1:0] != 2'b00);
         default: misalign = 1'b0;
      endcase
   end

   always_comb begin
      be_c    = 4'b1111;
      wdata_c = wdata;
      case (MemType[1:0])
         2'b00: begin
            be_c    = 4'b0001 << addr[1:0];
            wdata_c = {4{wdata[7:0]}};
         end
         2'b01: begin
            be_c    = addr[1] ? 4'b1100 : 4'b0011;
            wdata_c = {2{wdata[15:0]}};
         end
         default: begin
            be_c    = 4'b1111;
            wdata_c = wdata;
         end
      endcase
   end

   // Lane select and extension of the returned word, using the latched access.
   always_comb begin
      logic [7:0]  b;
      logic [15:0] h;
      case (ld_off)
         2'b00:   b = mem_rdata[7:0];
         2'b01:   b = mem_rdata[15:8];
         2'b10:   b = mem_rdata[23:16];
         default: b = mem_rdata[31:24];
      endcase
      h = ld_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (ld_type)
         3'b000:  ld_ext = {{24{b[7]}}, b};
         3'b001:  ld_ext = {{16{h[15]}}, h};
         3'b100:  ld_ext = {24'b0, b};
         3'b101:  ld_ext = {16'b0, h};
         default: ld_ext = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         cnt         <= 8'd0;
         ld_type     <= 3'd0;
         ld_off      <= 2'd0;
         is_load     <= 1'b0;
         done        <= 1'b0;
         rdata       <= 32'd0;
         rdata_valid <= 1'b0;
         err         <= 1'b0;
         err_code    <= 2'b00;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= 32'd0;
         mem_be      <= 4'd0;
         mem_wdata   <= 32'd0;
      end else begin
         case (state)
            S_IDLE: begin
               done        <= 1'b0;
               rdata_valid <= 1'b0;
               err         <= 1'b0;
               err_code    <= 2'b00;
               if (start) begin
                  if (illegal || misalign) begin
                     // Rejected accesses never touch the bus.
                     done     <= 1'b1;
                     err      <= 1'b1;
                     err_code <= illegal ? EC_ILLEGAL : EC_MISALIGN;
                     rdata    <= 32'd0;
                     state    <= S_DONE;
                  end else begin
                     mem_req   <= 1'b1;
                     mem_we    <= mw;
                     mem_addr  <= {addr[31:2], 2'b00};
                     mem_be    <= be_c;
                     mem_wdata <= wdata_c;
                     ld_type   <= MemType;
                     ld_off    <= addr[1:0];
                     is_load   <= mr;
                     cnt       <= 8'd0;
                     state     <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               if (mem_ready) begin
                  mem_req     <= 1'b0;
                  done        <= 1'b1;
                  rdata       <= is_load ? ld_ext : 32'd0;
                  rdata_valid <= is_load;
                  state       <= S_DONE;
               end else if (cnt == CNT_LAST) begin
                  // Request has now been held for TIMEOUT cycles.
                  mem_req  <= 1'b0;
                  done     <= 1'b1;
                  err      <= 1'b1;
                  err_code <= EC_TIMEOUT;
                  rdata    <= 32'd0;
                  state    <= S_DONE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            S_DONE: begin
               done        <= 1'b0;
               rdata_valid <= 1'b0;
               err         <= 1'b0;
               err_code    <= 2'b00;
               state       <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Load/store unit that acts on the memory-control outputs of the core's decode/control stage (`mr`, `mw`, `MemType`). It turns one decoded load or store into a single data-memory bus transaction with a request/ready handshake, generates byte enables and store-lane replication, and sign- or zero-extends load data. It stalls the pipeline until the access completes, and it flags misaligned, illegal and timed-out accesses.

## Interface
- `TIMEOUT`, default 255: maximum cycles in REQ waiting for `mem_ready` before abort (1..255).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset; asynchronous assert, active-low; one clock, reset is asynchronous and active-low.
- `mr` input 1: load request from control.
- `mw` input 1: store request from control.
- `MemType` input 3: funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- `addr` input 32: effective byte address.
- `wdata` input 32: store data (rs2).
- `stall` output 1: hold the pipeline (inputs held stable while high).
- `done` output 1: one-cycle completion pulse.
- `rdata` output 32: extended load result; valid when `rdata_valid`.
- `rdata_valid` output 1: one-cycle pulse, load completed without error.
- `err` output 1: one-cycle pulse with `done` when access failed.
- `err_code` output 2: 01 misaligned, 10 illegal (bad MemType or `mr`&`mw`), 11 timeout; 00 when `err`=0.
- `mem_req` output 1: bus request.
- `mem_we` output 1: 1 = write.
- `mem_addr` output 32: word-aligned address (`addr[31:2]`,2'b00).
- `mem_be` output 4: byte enables.
- `mem_wdata` output 32: replicated store data.
- `mem_ready` input 1: bus accept/complete.
- `mem_rdata` input 32: read word; sampled only when `mem_req`&`mem_ready`.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE: `start` = `mr`|`mw`. If `start` and the access is legal, latch type, address, `mem_be`, `mem_wdata` and `mem_we`=`mw`, clear the timeout counter, and go to REQ. If `start` and the access is illegal or misaligned, go to DONE with the error latched and no bus activity.
- Legality: both `mr` and `mw` set → illegal. Load MemType 011/110/111 → illegal. Store MemType other than 000/001/010 → illegal. Illegal takes priority over misaligned.
- Alignment: halfword requires `addr[0]`=0. Word requires `addr[1:0]`=0.
- REQ: `mem_req`=1 with all bus outputs stable. When `mem_ready`=1, capture the load lane and go to DONE. Otherwise increment the counter. When the counter reaches `TIMEOUT`, go to DONE with err_code 11 and `rdata`=0.
- DONE: `done`=1, `stall`=0, plus `rdata_valid` or `err` as applicable. Go to IDLE unconditionally, so the pipeline advances exactly one instruction.
- Byte enables: SB/LB/LBU use 0001<<`addr[1:0]`. SH/LH/LHU use 0011<<(2·`addr[1]`). Word uses 1111. Loads drive `mem_be` identically.
- Store data: SB replicates `wdata[7:0]` ×4. SH replicates `wdata[15:0]` ×2. SW passes `wdata` unchanged.
- Load extraction: select the byte or halfword by `addr[1:0]`. LB/LH sign-extend from bit 7/15. LBU/LHU zero-extend.
- `mem_ready` is ignored outside REQ.

## Timing
- `stall` is combinational: (IDLE & `start`) | REQ.
- All other outputs are registered.
- Reset values: state IDLE, counter 0, and `stall`, `done`, `rdata`, `rdata_valid`, `err`, `err_code`, `mem_req`, `mem_we`, `mem_addr`, `mem_be`, `mem_wdata` all 0.
- Zero-wait access:
  - cycle 0: IDLE, `stall`=1.
  - cycle 1: REQ, `mem_req`=1, `mem_ready`=1.
  - cycle 2: DONE, `done`=1, `stall`=0.
  - Result: 2 stall cycles. Each wait cycle of `mem_ready` adds one.
- Error in IDLE: cycle 0 `stall`=1, cycle 1 DONE with `err`. Result: 1 stall cycle.
- Timeout: `mem_req` is high for exactly `TIMEOUT` cycles, then DONE.
- `start` in DONE is ignored. It is evaluated in IDLE on the following cycle.
- Reset mid-transaction: `mem_req` and all outputs drop immediately (asynchronous). No `done`, no `err`.

## Test plan
- LW at `addr`=0x100, `mem_rdata`=0xDEADBEEF, `mem_ready` high in the first REQ cycle → `mem_addr`=0x100, `mem_be`=1111, `mem_we`=0. DONE two cycles after start with `rdata`=0xDEADBEEF and `rdata_valid`=1. `stall` high for exactly 2 cycles.
- LB at `addr`=0x103, `mem_rdata`=0x80FF7F01 → `mem_be`=1000, `rdata`=0xFFFFFF80. LBU at the same address → `rdata`=0x00000080. LH at 0x102 → `rdata`=0xFFFF80FF.
- SB at `addr`=0x201, `wdata`=0x12345678 → `mem_we`=1, `mem_be`=0010, `mem_wdata`=0x78787878. SH at 0x202 → `mem_be`=1100, `mem_wdata`=0x56785678.
- LW at 0x102 → no `mem_req`. DONE one cycle after start with `err`=1, `err_code`=01. `mw`&`mr` both set → `err_code`=10. Load MemType 011 → `err_code`=10.
- SW with `mem_ready` held low and `TIMEOUT`=4 → `mem_req` high for 4 cycles, then `err`=1, `err_code`=11, `rdata_valid`=0. A 3-cycle-wait LW → `stall` high for 5 cycles and `rdata` correct.
- `rst_n` pulsed low during REQ → `mem_req`=0 immediately, state IDLE, no `done`. A new LW after reset completes normally.
